// File: rtl/ct_spsram_req_ctrl.sv
// ct_spsram_req_ctrl: valid/ready front end for a single-port SRAM with a 2-entry read response buffer.
// Optional macro SPSRAM_INIT_EN adds a zero-fill sweep of the whole SRAM after reset.
module ct_spsram_req_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  init_done
);

  logic                  live;
  logic                  rd_inflight;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_e0;
  logic [DATA_WIDTH-1:0] fifo_e1;
  logic [1:0]            occ;
  logic                  req_acc;
  logic                  push;
  logic                  pop;
  logic                  sweep;
  logic [ADDR_WIDTH-1:0] sweep_a;

  // live holds the SRAM idle while reset is asserted, even with req_vld high
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) live <= 1'b0;
    else           live <= 1'b1;
  end

`ifdef SPSRAM_INIT_EN
  // state   | meaning
  // ST_INIT | zero-fill sweep, one address per cycle, requests blocked
  // ST_IDLE | sweep finished, normal request traffic
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [0:0] state;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= ST_INIT;
      sweep_a <= '0;
    end else if (sweep) begin
      sweep_a <= sweep_a + 1'b1;
      if (&sweep_a) state <= ST_IDLE;
    end
  end

  assign sweep     = live & (state == ST_INIT);
  assign init_done = (state == ST_IDLE);
`else
  assign sweep     = 1'b0;
  assign sweep_a   = '0;
  assign init_done = 1'b1;
`endif

  // Credit is conservative: a pop in this cycle does not free a slot until next cycle
  assign occ     = fifo_cnt + {1'b0, rd_inflight};
  assign req_rdy = init_done & live & (occ < 2'd2);
  assign req_acc = req_vld & req_rdy;
  assign push    = rd_inflight;
  assign rsp_vld = (fifo_cnt != 2'd0);
  assign pop     = rsp_vld & rsp_rdy;
  assign rsp_rdata = fifo_e0;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) rd_inflight <= 1'b0;
    else           rd_inflight <= req_acc & ~req_wr;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      fifo_cnt <= 2'd0;
      fifo_e0  <= '0;
      fifo_e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo_e0 <= sram_q;
          else                  fifo_e1 <= sram_q;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_e0  <= fifo_e1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_e0 <= sram_q;
          end else begin
            fifo_e0 <= fifo_e1;
            fifo_e1 <= sram_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = req_addr;
    sram_d    = req_wdata;
    if (sweep) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = sweep_a;
      sram_d    = '0;
    end else if (req_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = ~req_wr;
      sram_wen  = req_wr ? ~req_wmask : '1;
    end
  end

endmodule

// File: tb/tb_ct_spsram_req_ctrl.sv
// Directed bench for ct_spsram_req_ctrl with a behavioural single-port SRAM (1-cycle read latency).
// Define SPSRAM_INIT_EN to build with ADDR_WIDTH=4 and exercise the zero-fill sweep.
module tb_ct_spsram_req_ctrl;

`ifdef SPSRAM_INIT_EN
  localparam int AW = 4;
`else
  localparam int AW = 15;
`endif
  localparam int DW = 128;
  localparam logic [DW-1:0] A5    = {16{8'hA5}};
  localparam logic [DW-1:0] PMASK = 128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;
  localparam logic [DW-1:0] PEXP  = 128'hFF00_0000_0000_0000_0000_0000_0000_00FF;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic          init_done;

  int vectors = 0;
  int miscompares = 0;
  int cen_lows = 0;
  int outst = 0;
  int max_outst = 0;

  always #5 clk = ~clk;

  ct_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_b),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .init_done(init_done)
  );

  // Behavioural SRAM: bits with wen low take the new data
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] old_word;
  always @(posedge clk) begin
    if (sram_cen === 1'b0) begin
      if (sram_gwen === 1'b0) begin
        old_word = mem.exists(sram_a) ? mem[sram_a] : '0;
        mem[sram_a] = (old_word & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        sram_q <= mem.exists(sram_a) ? mem[sram_a] : '0;
      end
    end
  end

  always @(posedge clk) if (rst_b === 1'b1 && sram_cen === 1'b0) cen_lows++;

  // Outstanding reads = accepted but not yet popped; the buffer holds 2
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) outst = 0;
    else begin
      outst = outst + ((req_vld && req_rdy && !req_wr) ? 1 : 0) - ((rsp_vld && rsp_rdy) ? 1 : 0);
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m, output bit ok);
    ok = 1'b0;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (req_rdy === 1'b1) ok = 1'b1;
      @(negedge clk); #1;
    end
    req_vld = 1'b0; req_wr = 1'b0;
  endtask

  task automatic recv(output logic [DW-1:0] d, output bit ok);
    ok = 1'b0; d = '0; rsp_rdy = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (rsp_vld === 1'b1) begin ok = 1'b1; d = rsp_rdata; end
      @(negedge clk); #1;
    end
  endtask

`ifndef SPSRAM_INIT_EN
  function automatic logic [DW-1:0] dpat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'(i * 7), 32'hFFFF_FFFF - 32'(i), 32'(i)};
  endfunction

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_vld: got %b exp 0", rsp_vld); end
    vectors++; if (sram_cen !== 1'b1) begin miscompares++; $display("FAIL rst_cen: got %b exp 1", sram_cen); end
    vectors++; if (sram_gwen !== 1'b1) begin miscompares++; $display("FAIL rst_gwen: got %b exp 1", sram_gwen); end
    vectors++; if (sram_wen !== '1) begin miscompares++; $display("FAIL rst_wen: got %h exp all ones", sram_wen); end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL rst_init_done: got %b exp 1", init_done); end
    rst_b = 1'b1;
    @(negedge clk); #1;
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_req_rdy: got %b exp 1", req_rdy); end
  endtask

  task automatic test_write_read();
    bit ok;
    int c0;
    c0 = cen_lows;
    rsp_rdy = 1'b1;
    send(1'b1, AW'(16'h0010), A5, '1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_accept: got 0 exp 1"); end
    send(1'b0, AW'(16'h0010), '0, '0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_accept: got 0 exp 1"); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rd_lat_n1: got %b exp 0", rsp_vld); end
    @(negedge clk); #1;
    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL rd_lat_n2: got %b exp 1", rsp_vld); end
    vectors++; if (rsp_rdata !== A5) begin miscompares++; $display("FAIL rd_data: got %h exp %h", rsp_rdata, A5); end
    @(negedge clk); #1;
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rd_pop: got %b exp 0", rsp_vld); end
    vectors++; if (cen_lows - c0 !== 2) begin miscompares++; $display("FAIL cen_cycles: got %0d exp 2", cen_lows - c0); end
  endtask

  task automatic test_partial_write();
    bit ok;
    logic [DW-1:0] d;
    send(1'b1, AW'(16'h7FFF), '1, '1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pw_preload: got 0 exp 1"); end
    req_vld = 1'b1; req_wr = 1'b1; req_addr = AW'(16'h7FFF); req_wdata = '0; req_wmask = PMASK;
    #1;
    vectors++; if (sram_wen !== ~PMASK) begin miscompares++; $display("FAIL pw_wen: got %h exp %h", sram_wen, ~PMASK); end
    vectors++; if (sram_cen !== 1'b0 || sram_gwen !== 1'b0) begin miscompares++; $display("FAIL pw_cen_gwen: got %b%b exp 00", sram_cen, sram_gwen); end
    @(negedge clk); #1;
    req_vld = 1'b0; req_wr = 1'b0;
    send(1'b0, AW'(16'h7FFF), '0, '0, ok);
    recv(d, ok);
    vectors++; if (!ok || d !== PEXP) begin miscompares++; $display("FAIL pw_data: got %h exp %h", d, PEXP); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] addrs [4];
    bit exp_rdy [4];
    int i, acc;
    addrs = '{AW'(16'h0010), AW'(16'h7FFF), AW'(16'h0020), AW'(16'h0021)};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
    i = 0; acc = 0;
    rsp_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = addrs[i];
      #1;
      vectors++; if (req_rdy !== exp_rdy[c]) begin miscompares++; $display("FAIL bp_rdy%0d: got %b exp %b", c, req_rdy, exp_rdy[c]); end
      if (req_rdy === 1'b1) begin i++; acc++; end
      @(negedge clk); #1;
    end
    vectors++; if (acc !== 2) begin miscompares++; $display("FAIL bp_accepts: got %0d exp 2", acc); end
    for (int c = 0; c < 3; c++) begin
      vectors++; if (rsp_vld !== 1'b1 || rsp_rdata !== A5) begin miscompares++; $display("FAIL bp_hold%0d: got %b/%h exp 1/%h", c, rsp_vld, rsp_rdata, A5); end
      @(negedge clk); #1;
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk); #1;
    vectors++; if (rsp_vld !== 1'b1 || rsp_rdata !== PEXP) begin miscompares++; $display("FAIL bp_second: got %b/%h exp 1/%h", rsp_vld, rsp_rdata, PEXP); end
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_rdy_back: got %b exp 1", req_rdy); end
    @(negedge clk); #1;
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b exp 0", rsp_vld); end
  endtask

  task automatic test_streaming();
    bit ok;
    int bad_wr, bad_rd, k, cyc;
    bad_wr = 0; bad_rd = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, AW'(i), dpat(i), '1, ok);
      if (!ok) bad_wr++;
    end
    vectors++; if (bad_wr !== 0) begin miscompares++; $display("FAIL st_preload: got %0d stalls exp 0", bad_wr); end
    rsp_rdy = 1'b1;
    max_outst = 0;
    k = 0; cyc = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(1'b0, AW'(i), '0, '0, ok);
          if (!ok) bad_rd++;
        end
      end
      begin
        while (k < 16 && cyc < 60) begin
          if (rsp_vld === 1'b1) begin
            vectors++;
            if (rsp_rdata !== dpat(k)) begin miscompares++; $display("FAIL st_data%0d: got %h exp %h", k, rsp_rdata, dpat(k)); end
            k++;
          end
          cyc++;
          @(negedge clk); #1;
        end
      end
    join
    vectors++; if (bad_rd !== 0) begin miscompares++; $display("FAIL st_req_stall: got %0d exp 0", bad_rd); end
    vectors++; if (k !== 16) begin miscompares++; $display("FAIL st_count: got %0d exp 16", k); end
    vectors++; if (cyc > 30) begin miscompares++; $display("FAIL st_cycles: got %0d exp <=30", cyc); end
    vectors++; if (max_outst > 2) begin miscompares++; $display("FAIL st_occupancy: got %0d exp <=2", max_outst); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [DW-1:0] d;
    rsp_rdy = 1'b0;
    send(1'b0, AW'(0), '0, '0, ok);
    send(1'b0, AW'(1), '0, '0, ok);
    @(negedge clk); #1;
    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL rm_buffered: got %b exp 1", rsp_vld); end
    req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(3);
    #2;
    rst_b = 1'b0;
    #1;
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rm_rsp_vld: got %b exp 0", rsp_vld); end
    vectors++; if (sram_cen !== 1'b1) begin miscompares++; $display("FAIL rm_cen: got %b exp 1", sram_cen); end
    req_vld = 1'b0;
    @(negedge clk); #1;
    rst_b = 1'b1;
    rsp_rdy = 1'b1;
    send(1'b0, AW'(2), '0, '0, ok);
    recv(d, ok);
    vectors++; if (!ok || d !== dpat(2)) begin miscompares++; $display("FAIL rm_data: got %h exp %h", d, dpat(2)); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rm_stale: got %b exp 0", rsp_vld); end
  endtask
`else
  task automatic test_init_sweep();
    bit ok;
    logic [DW-1:0] d;
    int sweeps, bad, cyc;
    for (int i = 0; i < 16; i++) mem[AW'(i)] = '1;
    rst_b = 1'b0;
    @(negedge clk); #1;
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL in_rst_done: got %b exp 0", init_done); end
    vectors++; if (sram_cen !== 1'b1) begin miscompares++; $display("FAIL in_rst_cen: got %b exp 1", sram_cen); end
    rst_b = 1'b1;
    sweeps = 0; bad = 0; cyc = 0;
    while (init_done !== 1'b1 && cyc < 40) begin
      if (sram_cen === 1'b0) begin
        if (sram_a !== AW'(sweeps) || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0) bad++;
        sweeps++;
      end
      if (req_rdy !== 1'b0) bad++;
      cyc++;
      @(negedge clk); #1;
    end
    vectors++; if (sweeps !== 16) begin miscompares++; $display("FAIL in_sweep_len: got %0d exp 16", sweeps); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL in_sweep_drive: got %0d bad cycles exp 0", bad); end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL in_done: got %b exp 1", init_done); end
    rsp_rdy = 1'b1;
    send(1'b0, AW'(5), '0, '0, ok);
    recv(d, ok);
    vectors++; if (!ok || d !== '0) begin miscompares++; $display("FAIL in_read5: got %h exp 0", d); end
    send(1'b0, AW'(15), '0, '0, ok);
    recv(d, ok);
    vectors++; if (!ok || d !== '0) begin miscompares++; $display("FAIL in_read15: got %h exp 0", d); end
  endtask

  task automatic test_init_restart();
    bit found;
    int cyc;
    logic [AW-1:0] first_a;
    rst_b = 1'b0;
    @(negedge clk); #1;
    rst_b = 1'b1;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 40) begin
      if (sram_cen === 1'b0 && sram_a === AW'(7)) found = 1'b1;
      else begin cyc++; @(negedge clk); #1; end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL ir_reach7: got 0 exp 1"); end
    rst_b = 1'b0;
    #1;
    vectors++; if (sram_cen !== 1'b1 || init_done !== 1'b0) begin miscompares++; $display("FAIL ir_rst: got cen %b done %b exp 1 0", sram_cen, init_done); end
    @(negedge clk); #1;
    rst_b = 1'b1;
    found = 1'b0; cyc = 0; first_a = '1;
    while (!found && cyc < 10) begin
      if (sram_cen === 1'b0) begin found = 1'b1; first_a = sram_a; end
      else begin cyc++; @(negedge clk); #1; end
    end
    vectors++; if (!found || first_a !== '0) begin miscompares++; $display("FAIL ir_restart: got %h exp 0", first_a); end
    cyc = 0;
    while (init_done !== 1'b1 && cyc < 40) begin cyc++; @(negedge clk); #1; end
    vectors++; if (init_done !== 1'b1 || cyc !== 16) begin miscompares++; $display("FAIL ir_done: got %b after %0d exp 1 after 16", init_done, cyc); end
  endtask
`endif

  initial begin
    rst_b = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
    sram_q = '0;
    @(negedge clk); #1;
`ifdef SPSRAM_INIT_EN
    test_init_sweep();
    test_init_restart();
`else
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_streaming();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
